// File: rtl/lsu_pkg.sv
// lsu_pkg: definitions shared by the load sequencer, LoadUnit and the store path.
//   - RV32I load funct3 codes
//   - load sequencer FSM state encoding
//   - helpers to classify a load (legal / crosses a word boundary)
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD0  = 2'd1,
    ST_RD1  = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  function automatic logic is_legal_load(input logic [2:0] funct3);
    return (funct3 == F3_LB)  || (funct3 == F3_LH)  || (funct3 == F3_LW) ||
           (funct3 == F3_LBU) || (funct3 == F3_LHU);
  endfunction

  // True when the access spills into the next aligned word.
  function automatic logic is_split(input logic [2:0] funct3, input logic [1:0] addr_lo);
    return ((funct3 == F3_LW) && (addr_lo != 2'b00)) ||
           (((funct3 == F3_LH) || (funct3 == F3_LHU)) && (addr_lo == 2'b11));
  endfunction

endpackage

// File: rtl/load_unit.sv
// load_unit: combinational byte/half/word extraction with sign/zero extension.
//   word0   - aligned word containing the first byte of the access
//   word1   - following aligned word (only meaningful for split accesses)
//   funct3  - RV32I load type
//   addr_lo - byte offset of the access within word0
//   data    - extended 32-bit load result (0 for an illegal funct3)
module load_unit
  import lsu_pkg::*;
(
  input  logic [31:0] word0,
  input  logic [31:0] word1,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] data
);

  logic [63:0] pair;
  logic [31:0] shifted;

  // Little-endian: the addressed byte becomes bit 0 after shifting the word pair.
  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    data    = '0;
    pair    = {word1, word0};
    shifted = pair[{addr_lo, 3'b000} +: 32];
    case (funct3)
      F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LW:   data = shifted;
      F3_LBU:  data = {24'd0, shifted[7:0]};
      F3_LHU:  data = {16'd0, shifted[15:0]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/load_seq_ctrl.sv
// load_seq_ctrl: sequences data-memory word reads for RV32I loads.
//   Request side : i_req_valid/o_req_ready, i_req_addr, i_req_funct3, i_flush
//   Memory side  : o_mem_req, o_mem_addr (word aligned), i_mem_ack, i_mem_rdata
//   Response side: o_rsp_valid/i_rsp_ready, o_rsp_data, o_rsp_err
// One load in flight at a time; one word read, or two when the access crosses
// a word boundary. Each read is bounded by TIMEOUT cycles; a timeout or an
// illegal funct3 produces an error response with zero data.
module load_seq_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic [2:0]  i_req_funct3,
  input  logic        i_flush,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_err
);

  // Last wait cycle index: the read is abandoned after this cycle without ack.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  lsu_state_e  state_q;
  logic [1:0]  addr_lo_q;
  logic [2:0]  funct3_q;
  logic        split_q;
  logic [31:0] word0_q;
  logic [31:0] word1_q;
  logic [7:0]  wait_cnt_q;
  logic [31:0] lu_data;

  assign o_req_ready = (state_q == ST_IDLE);

  load_unit u_load_unit (
    .word0   (word0_q),
    .word1   (word1_q),
    .funct3  (funct3_q),
    .addr_lo (addr_lo_q),
    .data    (lu_data)
  );

  // Data is only presented with a good response; error responses read as zero.
  assign o_rsp_data = (o_rsp_valid && !o_rsp_err) ? lu_data : 32'd0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      addr_lo_q   <= '0;
      funct3_q    <= '0;
      split_q     <= 1'b0;
      word0_q     <= '0;
      word1_q     <= '0;
      wait_cnt_q  <= '0;
      o_mem_req   <= 1'b0;
      o_mem_addr  <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
    end else if (i_flush) begin
      // Abort from any state; an ack in this cycle is deliberately dropped.
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      o_mem_req   <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_req_valid) begin
            addr_lo_q  <= i_req_addr[1:0];
            funct3_q   <= i_req_funct3;
            split_q    <= is_split(i_req_funct3, i_req_addr[1:0]);
            word0_q    <= '0;
            word1_q    <= '0;
            wait_cnt_q <= '0;
            if (is_legal_load(i_req_funct3)) begin
              state_q    <= ST_RD0;
              o_mem_req  <= 1'b1;
              o_mem_addr <= {i_req_addr[31:2], 2'b00};
            end else begin
              state_q     <= ST_RESP;
              o_rsp_valid <= 1'b1;
              o_rsp_err   <= 1'b1;
            end
          end
        end

        ST_RD0, ST_RD1: begin
          // An ack in the final wait cycle takes priority over the timeout.
          if (i_mem_ack) begin
            wait_cnt_q <= '0;
            if (state_q == ST_RD0) word0_q <= i_mem_rdata;
            else                   word1_q <= i_mem_rdata;
            if ((state_q == ST_RD0) && split_q) begin
              state_q    <= ST_RD1;
              o_mem_addr <= o_mem_addr + 32'd4;  // wraps past 0xFFFFFFFC
            end else begin
              state_q     <= ST_RESP;
              o_mem_req   <= 1'b0;
              o_rsp_valid <= 1'b1;
            end
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_q     <= ST_RESP;
            o_mem_req   <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end

        ST_RESP: begin
          if (i_rsp_ready) begin
            state_q     <= ST_IDLE;
            o_rsp_valid <= 1'b0;
            o_rsp_err   <= 1'b0;
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          o_mem_req   <= 1'b0;
          o_rsp_valid <= 1'b0;
          o_rsp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_seq_ctrl.sv
// Directed testbench for load_seq_ctrl (TIMEOUT = 16).
module tb_load_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  int checks   = 0;
  int failures = 0;

  load_seq_ctrl #(.TIMEOUT(16)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_addr   (req_addr),
    .i_req_funct3 (req_funct3),
    .i_flush      (flush),
    .o_mem_req    (mem_req),
    .o_mem_addr   (mem_addr),
    .i_mem_ack    (mem_ack),
    .i_mem_rdata  (mem_rdata),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_data   (rsp_data),
    .o_rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] addr, input logic [2:0] f3);
    req_valid  = 1'b1;
    req_addr   = addr;
    req_funct3 = f3;
    step();
    req_valid  = 1'b0;
  endtask

  task automatic ack_with(input logic [31:0] data);
    mem_ack   = 1'b1;
    mem_rdata = data;
    step();
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n_req;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_funct3 = '0; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0; rsp_ready = 1'b0;
    #1;
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset mem_req",   32'(mem_req),   32'd0);
    check("reset mem_addr",  mem_addr,       32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_data",  rsp_data,       32'd0);
    check("reset rsp_err",   32'(rsp_err),   32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Aligned LW at 0x100, ack in the first read cycle.
    issue(32'h0000_0100, 3'b010);
    check("lw0 mem_req",   32'(mem_req),   32'd1);
    check("lw0 mem_addr",  mem_addr,       32'h0000_0100);
    check("lw0 req_ready", 32'(req_ready), 32'd0);
    check("lw0 rsp_valid", 32'(rsp_valid), 32'd0);
    ack_with(32'hDEAD_BEEF);
    check("lw0 rsp_valid", 32'(rsp_valid), 32'd1);
    check("lw0 mem_req off", 32'(mem_req), 32'd0);
    check("lw0 rsp_data",  rsp_data,       32'hDEAD_BEEF);
    check("lw0 rsp_err",   32'(rsp_err),   32'd0);
    handshake();
    check("lw0 done rsp_valid", 32'(rsp_valid), 32'd0);
    check("lw0 done req_ready", 32'(req_ready), 32'd1);

    // Split LW at 0x103; response held for three cycles before acceptance.
    issue(32'h0000_0103, 3'b010);
    check("lws addr0", mem_addr, 32'h0000_0100);
    ack_with(32'h1122_3344);
    check("lws rd1 mem_req",   32'(mem_req),   32'd1);
    check("lws addr1",         mem_addr,       32'h0000_0104);
    check("lws rd1 rsp_valid", 32'(rsp_valid), 32'd0);
    ack_with(32'hAABB_CCDD);
    for (int i = 0; i < 3; i++) begin
      check("lws hold valid", 32'(rsp_valid), 32'd1);
      check("lws hold data",  rsp_data,       32'hBBCC_DD11);
      step();
    end
    handshake();
    check("lws done req_ready", 32'(req_ready), 32'd1);

    // LH / LHU at 0xFFFFFFFF: second read wraps to address 0.
    issue(32'hFFFF_FFFF, 3'b001);
    check("lh addr0", mem_addr, 32'hFFFF_FFFC);
    ack_with(32'h8000_0000);
    check("lh addr1 wrap", mem_addr, 32'h0000_0000);
    ack_with(32'h0000_00FF);
    check("lh rsp_data", rsp_data, 32'hFFFF_FF80);
    check("lh rsp_err",  32'(rsp_err), 32'd0);
    handshake();
    issue(32'hFFFF_FFFF, 3'b101);
    ack_with(32'h8000_0000);
    check("lhu addr1 wrap", mem_addr, 32'h0000_0000);
    ack_with(32'h0000_00FF);
    check("lhu rsp_data", rsp_data, 32'h0000_FF80);
    handshake();

    // Memory never acks: request held exactly TIMEOUT cycles, then error.
    issue(32'h0000_0200, 3'b010);
    n_req = 0;
    for (int i = 0; i < 40 && mem_req; i++) begin
      n_req++;
      step();
    end
    check("timeout req cycles", 32'(n_req),     32'd16);
    check("timeout rsp_valid",  32'(rsp_valid), 32'd1);
    check("timeout rsp_err",    32'(rsp_err),   32'd1);
    check("timeout rsp_data",   rsp_data,       32'd0);
    handshake();

    // Ack in the final (16th) wait cycle wins over the timeout.
    issue(32'h0000_0300, 3'b010);
    for (int i = 0; i < 15; i++) step();
    check("late ack mem_req", 32'(mem_req), 32'd1);
    ack_with(32'hCAFE_F00D);
    check("late ack rsp_valid", 32'(rsp_valid), 32'd1);
    check("late ack rsp_err",   32'(rsp_err),   32'd0);
    check("late ack rsp_data",  rsp_data,       32'hCAFE_F00D);
    handshake();

    // Illegal funct3: no memory access, error response one cycle after accept.
    issue(32'h0000_0400, 3'b011);
    for (int i = 0; i < 5; i++) begin
      check("illegal mem_req",   32'(mem_req),   32'd0);
      check("illegal rsp_valid", 32'(rsp_valid), 32'd1);
      check("illegal rsp_err",   32'(rsp_err),   32'd1);
      check("illegal rsp_data",  rsp_data,       32'd0);
      step();
    end
    handshake();
    check("illegal done req_ready", 32'(req_ready), 32'd1);
    check("illegal done rsp_valid", 32'(rsp_valid), 32'd0);

    // Flush during RD1 of a split LW; the coincident and a later ack are ignored.
    issue(32'h0000_0107, 3'b010);
    ack_with(32'h5555_5555);
    check("flush rd1 addr", mem_addr, 32'h0000_0108);
    flush = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    step();
    flush = 1'b0;
    check("flush req_ready", 32'(req_ready), 32'd1);
    check("flush mem_req",   32'(mem_req),   32'd0);
    check("flush rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    mem_ack = 1'b0;
    check("flush late ack rsp_valid", 32'(rsp_valid), 32'd0);
    check("flush late ack mem_req",   32'(mem_req),   32'd0);

    // Flush in IDLE blocks acceptance.
    flush = 1'b1;
    issue(32'h0000_0500, 3'b010);
    flush = 1'b0;
    check("idle flush mem_req",   32'(mem_req),   32'd0);
    check("idle flush req_ready", 32'(req_ready), 32'd1);

    // Asynchronous reset in the middle of RD0.
    issue(32'h0000_0600, 3'b010);
    check("rst mid rd0 mem_req before", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst async mem_req",   32'(mem_req),   32'd0);
    check("rst async mem_addr",  mem_addr,       32'd0);
    check("rst async req_ready", 32'(req_ready), 32'd1);
    check("rst async rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst async rsp_err",   32'(rsp_err),   32'd0);
    #2 rst_n = 1'b1;
    step();

    // Byte loads after reset: byte 2 of 0x00A50000.
    issue(32'h0000_0702, 3'b000);
    check("lb addr", mem_addr, 32'h0000_0700);
    ack_with(32'h00A5_0000);
    check("lb rsp_data", rsp_data, 32'hFFFF_FFA5);
    handshake();
    issue(32'h0000_0702, 3'b100);
    ack_with(32'h00A5_0000);
    check("lbu rsp_data", rsp_data, 32'h0000_00A5);
    handshake();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_seq_ctrl.md
# load_seq_ctrl

Sequences data-memory reads for RV32I loads and drives the existing LoadUnit byte/half/word extraction block. It accepts one load request at a time from the execute/memory stage and issues one aligned word read, or two when the access crosses a word boundary. It returns the extended 32-bit result to writeback over a valid/ready handshake. A per-read timeout flags a memory that never acknowledges.

## Interface
Parameters:
- TIMEOUT, 16: max cycles to wait for i_mem_ack per word read; range 2..255.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  reset, asynchronous and active-low.
- i_req_valid  in  1  load request valid.
- o_req_ready  out  1  controller can accept a request.
- i_req_addr  in  32  byte address.
- i_req_funct3  in  3  load type (LB 000, LH 001, LW 010, LBU 100, LHU 101).
- i_flush  in  1  abort the current load.
- o_mem_req  out  1  word read request.
- o_mem_addr  out  32  word-aligned read address.
- i_mem_ack  in  1  read complete; i_mem_rdata is valid this cycle.
- i_mem_rdata  in  32  read data.
- o_rsp_valid  out  1  result valid.
- i_rsp_ready  in  1  writeback accepts the result.
- o_rsp_data  out  32  extended load result.
- o_rsp_err  out  1  result is an error (illegal funct3 or timeout); o_rsp_data = 0.

## Operation
- FSM states: IDLE, RD0, RD1, RESP.
- IDLE: o_req_ready=1. Accept when i_req_valid=1.
  - Latch addr, funct3.
  - Clear word0/word1.
  - Compute split = (LW and addr[1:0]!=0) or (LH/LHU and addr[1:0]==3).
- Illegal funct3: go directly to RESP with err=1, data=0, and no memory access.
- Legal funct3: go to RD0.
- RD0: o_mem_req=1, o_mem_addr={addr[31:2],2'b00}.
  - On i_mem_ack, latch word0.
  - If split, go to RD1; otherwise go to RESP.
- RD1: o_mem_req=1, o_mem_addr={addr[31:2],2'b00}+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000). On i_mem_ack, latch word1 and go to RESP.
- RESP: o_rsp_valid=1.
  - o_rsp_data = LoadUnit(word0, word1, funct3, addr[1:0]), or 0 when err.
  - Outputs are held stable until i_rsp_ready=1, then go to IDLE.
- Wait counter: cleared on entry to RD0/RD1, increments each cycle without ack.
  - If the counter reaches TIMEOUT-1 with no ack, go to RESP with err=1 and drop o_mem_req next cycle.
  - An ack arriving in the timeout cycle wins (no error).
- i_flush: from any state, go to IDLE next cycle.
  - o_mem_req and o_rsp_valid drop next cycle; any ack in that cycle is ignored.
  - The memory tolerates o_mem_req deasserting without ack.
  - i_flush in IDLE blocks acceptance that cycle.
- Unused word1 stays 0; LoadUnit ignores it on non-split accesses.

## Timing
- Reset (async assert):
  - state=IDLE, o_req_ready=1.
  - o_mem_req=0, o_mem_addr=0.
  - o_rsp_valid=0, o_rsp_data=0, o_rsp_err=0.
  - Internal registers 0.
- Reset mid-read: o_mem_req drops immediately (asynchronously); the in-flight read is abandoned.
- o_mem_req, o_mem_addr, o_rsp_valid and o_rsp_err are registered state decodes with no combinational path from inputs. o_req_ready is a state decode.
- Latency with ack in the first RD cycle: accept cycle N, RD0 at N+1, RESP at N+2 (aligned) or N+3 (split).
- Each wait cycle without ack adds one cycle.
- Throughput: at most one load per 3 cycles (aligned) or 4 (split). No request pipelining.
- A response accepted in cycle M gives o_req_ready=1 at M+1.

## Structure
- Shared package (lsu_pkg), reused by LoadUnit and the store path:
  - funct3 load codes (LB, LH, LW, LBU, LHU);
  - FSM state enum;
  - a function is_split(funct3, addr_lo).
- Sub-module: the existing LoadUnit, instantiated as the combinational extractor fed from the word0/word1 registers. The timeout counter stays inline.
- Estimated 150-250 RTL lines.

## Test plan
- Aligned LW at 0x100, memory returns 0xDEADBEEF with ack in the first cycle -> exactly one read at 0x100; o_rsp_data=0xDEADBEEF, err=0; o_rsp_valid rises 2 cycles after accept.
- Split LW at 0x103, words 0x11223344 then 0xAABBCCDD -> reads at 0x100 then 0x104; o_rsp_data=0xBBCCDD11.
- LH at 0xFFFFFFFF, words 0x80000000 then 0x000000FF -> second read at 0x00000000; o_rsp_data=0xFFFFFF80. LHU at the same address -> 0x0000FF80.
- Memory never acks, TIMEOUT=16 -> o_mem_req high for exactly 16 cycles, then o_rsp_valid=1, o_rsp_err=1, o_rsp_data=0. Ack in cycle 16 -> normal data, err=0.
- funct3=011 -> no o_mem_req; RESP with err=1 one cycle after accept. i_rsp_ready held 0 for 5 cycles -> o_rsp_valid and data stay stable; o_req_ready=1 the cycle after the handshake.
- i_flush during RD1 of a split LW -> IDLE next cycle, no response; a late ack is ignored. i_rst_n pulsed low mid-RD0 -> all outputs reach reset values immediately.
